// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Constants shared by the trap controller and its CSR file: exception codes,
// trap CSR addresses, controller state encoding, and the helper that picks the
// trap value (mtval) for a given cause.
// -----------------------------------------------------------------------------
package trap_pkg;

   // Exception codes as produced by the exception signals handler.
   localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
   localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
   localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
   localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
   localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
   localparam logic [3:0] E_STORE_ADDR_FAULT      = 4'd7;
   localparam logic [3:0] E_ECALL                 = 4'd11;
   localparam logic [3:0] E_SP_OUT_OF_RANGE       = 4'd14;
   localparam logic [3:0] NO_E                    = 4'd15;

   // Machine-mode trap CSR addresses.
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   typedef enum logic [1:0] {
      S_BOOT    = 2'd0,
      S_RUN     = 2'd1,
      S_HANDLER = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   // Address faults report the effective address, instruction faults report
   // the faulting PC, everything else reports zero.
   function automatic logic [31:0] trap_value(input logic [3:0]  code,
                                              input logic [31:0] pc,
                                              input logic [31:0] addr);
      logic [31:0] val;
      case (code)
         E_LOAD_ADDR_MISALIGNED,
         E_LOAD_ACCESS_FAULT,
         E_STORE_ADDR_MISALIGNED,
         E_STORE_ADDR_FAULT:      val = addr;
         E_FETCH_ADDR_MISALIGNED,
         E_ILLEGAL_INSTR:         val = pc;
         default:                 val = 32'h0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/trap_controller_csr.sv
// -----------------------------------------------------------------------------
// trap_csr_file
// Holds mepc, mcause and mtval. A trap load has priority over a software
// write; the caller is responsible for gating i_we by state and by any
// redirect in the same cycle. Reads are combinational.
//
// Ports:
//   i_clk, i_rst_n    clock / asynchronous active-low reset
//   i_trap            load all three CSRs from the trap inputs
//   i_trap_pc         value for mepc on a trap
//   i_trap_cause      4-bit cause, zero-extended into mcause
//   i_trap_tval       value for mtval on a trap
//   i_we              qualified software write
//   i_addr            CSR address (read and write)
//   i_wdata           software write data
//   o_rdata           read data, 0 for unmapped addresses
//   o_mepc            current mepc, used as the mret target
// -----------------------------------------------------------------------------
module trap_csr_file
   import trap_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE = 32'h0008_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_trap,
   input  logic [31:0] i_trap_pc,
   input  logic [3:0]  i_trap_cause,
   input  logic [31:0] i_trap_tval,
   input  logic        i_we,
   input  logic [11:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic [31:0] o_mepc
);

   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the values that existed before the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mepc   <= TEXT_BASE;
         mcause <= 32'h0;
         mtval  <= 32'h0;
      end else if (i_trap) begin
         mepc   <= i_trap_pc;
         mcause <= {28'h0, i_trap_cause};
         mtval  <= i_trap_tval;
      end else if (i_we) begin
         case (i_addr)
            CSR_MEPC:   mepc   <= {i_wdata[31:2], 2'b00};  // word-aligned return target
            CSR_MCAUSE: mcause <= i_wdata;
            CSR_MTVAL:  mtval  <= i_wdata;
            default:    ;
         endcase
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // latch is inferred for unmapped addresses.
   always_comb begin
      o_rdata = 32'h0;
      case (i_addr)
         CSR_MEPC:   o_rdata = mepc;
         CSR_MCAUSE: o_rdata = mcause;
         CSR_MTVAL:  o_rdata = mtval;
         default:    ;
      endcase
   end

   assign o_mepc = mepc;

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
// Turns fetch- and execute-stage exception codes into precise machine-mode
// traps. Shadows the fetch code alongside the F/D and D/E registers, picks
// the effective cause for the instruction in E, runs the boot/run/handler/halt
// state machine and owns the trap-caused flush and PC redirect.
//
// Ports:
//   i_clk, i_rst_n          clock / asynchronous active-low reset
//   i_exception_code_f/e    fetch / execute exception codes (NO_E when clean)
//   i_pc_e, i_alu_out_e     PC and effective address of the instruction in E
//   i_mret_e                mret in E
//   i_stall_d               F/D register hold
//   i_flush_d, i_flush_e    pipeline flushes of D and E
//   i_csr_addr              CSR address for reads and writes
//   i_csr_we_e, i_csr_wdata_e  CSR write in E
//   o_csr_rdata             combinational CSR read
//   o_redirect, o_redirect_pc  PC override, same cycle as the decision
//   o_flush_all             flush F/D/E, identical to o_redirect
//   o_reset_permission      registered: state is S_BOOT
//   o_trap_permission       registered: state is S_HANDLER
//   o_halt                  registered: state is S_HALT (double fault, sticky)
// -----------------------------------------------------------------------------
module trap_controller
   import trap_pkg::*;
#(
   parameter logic [31:0] TRAP_BASE = 32'h0000_0000,
   parameter logic [31:0] TEXT_BASE = 32'h0008_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_exception_code_f,
   input  logic [3:0]  i_exception_code_e,
   input  logic [31:0] i_pc_e,
   input  logic [31:0] i_alu_out_e,
   input  logic        i_mret_e,
   input  logic        i_stall_d,
   input  logic        i_flush_d,
   input  logic        i_flush_e,
   input  logic [11:0] i_csr_addr,
   input  logic        i_csr_we_e,
   input  logic [31:0] i_csr_wdata_e,
   output logic [31:0] o_csr_rdata,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_flush_all,
   output logic        o_reset_permission,
   output logic        o_trap_permission,
   output logic        o_halt
);

   state_t      state;
   state_t      state_next;
   logic [3:0]  fc_d;
   logic [3:0]  fc_e;
   logic [3:0]  cause;
   logic [3:0]  trap_cause;
   logic        trap;
   logic        csr_we;
   logic [31:0] mepc;

   // A fetch fault travelling with the instruction outranks any execute fault
   // the same instruction raises.
   assign cause = (fc_e != NO_E) ? fc_e : i_exception_code_e;

   always_comb begin
      state_next    = state;
      trap          = 1'b0;
      trap_cause    = cause;
      o_redirect    = 1'b0;
      o_redirect_pc = TRAP_BASE;
      case (state)
         S_BOOT, S_HANDLER: begin
            if (cause != NO_E) begin
               // Fault with no handler to take it: halt and freeze fetch now.
               state_next    = S_HALT;
               o_redirect    = 1'b1;
               o_redirect_pc = i_pc_e;
            end else if (i_mret_e) begin
               state_next    = S_RUN;
               o_redirect    = 1'b1;
               o_redirect_pc = mepc;
            end
         end
         S_RUN: begin
            if (cause != NO_E) begin
               trap = 1'b1;
            end else if (i_mret_e) begin
               // mret is privileged to the handler; in user code it is illegal.
               trap       = 1'b1;
               trap_cause = E_ILLEGAL_INSTR;
            end
            if (trap) begin
               state_next    = S_HANDLER;
               o_redirect    = 1'b1;
               o_redirect_pc = TRAP_BASE;
            end
         end
         S_HALT: begin
            // Re-fetching the instruction in E forever keeps the core frozen.
            o_redirect    = 1'b1;
            o_redirect_pc = i_pc_e;
         end
         default: ;
      endcase
   end

   assign o_flush_all = o_redirect;

   // Software CSR writes only from privileged states, and never in a cycle
   // that redirects (trap, mret or halt entry all drop the write).
   assign csr_we = i_csr_we_e && !o_redirect &&
                   ((state == S_BOOT) || (state == S_HANDLER));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state              <= S_BOOT;
         o_reset_permission <= 1'b1;
         o_trap_permission  <= 1'b0;
         o_halt             <= 1'b0;
      end else begin
         state              <= state_next;
         o_reset_permission <= (state_next == S_BOOT);
         o_trap_permission  <= (state_next == S_HANDLER);
         o_halt             <= (state_next == S_HALT);
      end
   end

   // Fetch-code shadow of the F/D and D/E pipeline registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fc_d <= NO_E;
         fc_e <= NO_E;
      end else begin
         if (o_flush_all || i_flush_d)
            fc_d <= NO_E;
         else if (!i_stall_d)
            fc_d <= i_exception_code_f;

         if (o_flush_all || i_flush_e)
            fc_e <= NO_E;
         else
            fc_e <= fc_d;
      end
   end

   trap_csr_file #(
      .TEXT_BASE (TEXT_BASE)
   ) u_csr (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_trap       (trap),
      .i_trap_pc    (i_pc_e),
      .i_trap_cause (trap_cause),
      .i_trap_tval  (trap_value(trap_cause, i_pc_e, i_alu_out_e)),
      .i_we         (csr_we),
      .i_addr       (i_csr_addr),
      .i_wdata      (i_csr_wdata_e),
      .o_rdata      (o_csr_rdata),
      .o_mepc       (mepc)
   );

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
// Cycle-by-cycle vector table walked from reset through boot, a load fault,
// handler return, fetch-fault priority, flush kill, illegal mret and a double
// fault, followed by hand-written sequences for asynchronous reset, stall and
// flush of the fetch-code shadow, and a fault during boot.
// -----------------------------------------------------------------------------
module tb_trap_controller;

   localparam logic [3:0] NF = 4'hF;   // no exception

   typedef struct {
      logic [3:0]  code_f;
      logic [3:0]  code_e;
      logic [31:0] pc;
      logic [31:0] alu;
      logic        mret;
      logic        stall;
      logic        flush_e;
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        e_redirect;
      logic [31:0] e_rpc;
      logic        e_rperm;
      logic        e_tperm;
      logic        e_halt;
      logic [31:0] e_rdata;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  code_f;
   logic [3:0]  code_e;
   logic [31:0] pc_e;
   logic [31:0] alu_e;
   logic        mret_e;
   logic        stall_d;
   logic        flush_d;
   logic        flush_e;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush_all;
   logic        reset_perm;
   logic        trap_perm;
   logic        halt;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t tv[$];

   trap_controller dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_exception_code_f (code_f),
      .i_exception_code_e (code_e),
      .i_pc_e             (pc_e),
      .i_alu_out_e        (alu_e),
      .i_mret_e           (mret_e),
      .i_stall_d          (stall_d),
      .i_flush_d          (flush_d),
      .i_flush_e          (flush_e),
      .i_csr_addr         (csr_addr),
      .i_csr_we_e         (csr_we),
      .i_csr_wdata_e      (csr_wdata),
      .o_csr_rdata        (csr_rdata),
      .o_redirect         (redirect),
      .o_redirect_pc      (redirect_pc),
      .o_flush_all        (flush_all),
      .o_reset_permission (reset_perm),
      .o_trap_permission  (trap_perm),
      .o_halt             (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      code_f = NF; code_e = NF; pc_e = 32'h0; alu_e = 32'h0;
      mret_e = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
      csr_addr = 12'h0; csr_we = 1'b0; csr_wdata = 32'h0;
   endtask

   // Advance one cycle: inputs change on the falling edge, away from posedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic add(input logic [3:0] cf, input logic [3:0] ce, input logic [31:0] pc,
                      input logic [31:0] alu, input logic mr, input logic st, input logic fe,
                      input logic [11:0] ad, input logic we, input logic [31:0] wd,
                      input logic red, input logic [31:0] rpc, input logic rp,
                      input logic tp, input logic h, input logic [31:0] rd);
      vec_t v;
      v.code_f = cf; v.code_e = ce; v.pc = pc; v.alu = alu; v.mret = mr;
      v.stall = st; v.flush_e = fe; v.addr = ad; v.we = we; v.wdata = wd;
      v.e_redirect = red; v.e_rpc = rpc; v.e_rperm = rp; v.e_tperm = tp;
      v.e_halt = h; v.e_rdata = rd;
      tv.push_back(v);
   endtask

   initial begin
      rst_n = 1'b1;
      idle();

      //   cf  ce   pc            alu           mr st fe addr    we wdata         red rpc          rp tp h  rdata
      // boot: mcause writable in S_BOOT, mret goes to TEXT_BASE
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h341, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0008_0000);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h342, 1, 32'h0000_00AB, 0, 32'h0,       1, 0, 0, 32'h0);
      add(NF, NF, 32'h0,        32'h0,        1, 0, 0, 12'h342, 0, 32'h0,        1, 32'h0008_0000, 1, 0, 0, 32'h0000_00AB);
      // run: CSR write ignored, then load access fault
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h341, 1, 32'h1234_5678, 0, 32'h0,       0, 0, 0, 32'h0008_0000);
      add(NF, 4'd5, 32'h0008_0010, 32'h0000_1234, 0, 0, 0, 12'h341, 0, 32'h0,     1, 32'h0,        0, 0, 0, 32'h0008_0000);
      // handler: inspect CSRs, rewrite mepc (low bits cleared), return
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h341, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0008_0010);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h342, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h5);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h343, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_1234);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h341, 1, 32'h0008_0027, 0, 32'h0,       0, 1, 0, 32'h0008_0010);
      add(NF, NF, 32'h0,        32'h0,        1, 0, 0, 12'h341, 0, 32'h0,        1, 32'h0008_0024, 0, 1, 0, 32'h0008_0024);
      // run: fetch fault 2 outranks execute ecall two cycles later
      add(4'd2, NF, 32'h0,      32'h0,        0, 0, 0, 12'h343, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_1234);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h000, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0);
      add(NF, 4'd11, 32'h0008_0020, 32'h0,    0, 0, 0, 12'h000, 0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h343, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0008_0020);
      // mret with a same-cycle mepc write: redirect to old mepc, write dropped
      add(NF, NF, 32'h0,        32'h0,        1, 0, 0, 12'h341, 1, 32'h0009_0000, 1, 32'h0008_0020, 0, 1, 0, 32'h0008_0020);
      add(4'd0, NF, 32'h0,      32'h0,        0, 0, 0, 12'h341, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0008_0020);
      // flush_e kills the fetch fault before it reaches E
      add(NF, NF, 32'h0,        32'h0,        0, 0, 1, 12'h000, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h342, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h2);
      // mret in run is an illegal instruction
      add(NF, NF, 32'h0008_0040, 32'h0,       1, 0, 0, 12'h000, 0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h343, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0008_0040);
      // double fault in handler, halt is absorbing
      add(NF, 4'd6, 32'h0008_0050, 32'h0000_9999, 0, 0, 0, 12'h341, 0, 32'h0,   1, 32'h0008_0050, 0, 1, 0, 32'h0008_0040);
      add(NF, NF, 32'h0008_0060, 32'h0,       0, 0, 0, 12'h341, 0, 32'h0,        1, 32'h0008_0060, 0, 0, 1, 32'h0008_0040);
      add(NF, NF, 32'h0008_0070, 32'h0,       1, 0, 0, 12'h341, 0, 32'h0,        1, 32'h0008_0070, 0, 0, 1, 32'h0008_0040);
      add(NF, NF, 32'h0008_0080, 32'h0,       0, 0, 0, 12'h341, 1, 32'hDEAD_BEEC, 1, 32'h0008_0080, 0, 0, 1, 32'h0008_0040);
      add(NF, NF, 32'h0,        32'h0,        0, 0, 0, 12'h341, 0, 32'h0,        1, 32'h0,        0, 0, 1, 32'h0008_0040);

      do_reset();

      for (int i = 0; i < tv.size(); i++) begin
         code_f = tv[i].code_f; code_e = tv[i].code_e; pc_e = tv[i].pc;
         alu_e = tv[i].alu; mret_e = tv[i].mret; stall_d = tv[i].stall;
         flush_d = 1'b0; flush_e = tv[i].flush_e; csr_addr = tv[i].addr;
         csr_we = tv[i].we; csr_wdata = tv[i].wdata;
         #1;
         check($sformatf("v%0d redirect", i), {31'h0, redirect}, {31'h0, tv[i].e_redirect});
         check($sformatf("v%0d flush_all", i), {31'h0, flush_all}, {31'h0, tv[i].e_redirect});
         if (tv[i].e_redirect)
            check($sformatf("v%0d redirect_pc", i), redirect_pc, tv[i].e_rpc);
         check($sformatf("v%0d reset_perm", i), {31'h0, reset_perm}, {31'h0, tv[i].e_rperm});
         check($sformatf("v%0d trap_perm", i), {31'h0, trap_perm}, {31'h0, tv[i].e_tperm});
         check($sformatf("v%0d halt", i), {31'h0, halt}, {31'h0, tv[i].e_halt});
         check($sformatf("v%0d csr_rdata", i), csr_rdata, tv[i].e_rdata);
         step();
      end

      // Asynchronous reset in the middle of a cycle while halted.
      idle();
      csr_addr = 12'h341;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst halt", {31'h0, halt}, 32'h0);
      check("async_rst reset_perm", {31'h0, reset_perm}, 32'h1);
      check("async_rst trap_perm", {31'h0, trap_perm}, 32'h0);
      check("async_rst mepc", csr_rdata, 32'h0008_0000);
      csr_addr = 12'h343;
      #1;
      check("async_rst mtval", csr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boot to run, then flush_d kills a fetch fault in D.
      mret_e = 1'b1;
      step();
      idle();
      code_f = 4'd0; flush_d = 1'b1;
      step();
      idle();
      step();
      #1;
      check("flush_d no trap", {31'h0, redirect}, 32'h0);
      step();

      // A stalled F/D keeps its fetch code; flush_e only drops the copy in E.
      code_f = 4'd0;
      step();
      idle();
      stall_d = 1'b1; flush_e = 1'b1;
      step();
      idle();
      #1;
      check("stall pre redirect", {31'h0, redirect}, 32'h0);
      step();
      pc_e = 32'h0008_0100;
      #1;
      check("stall trap redirect", {31'h0, redirect}, 32'h1);
      check("stall trap pc", redirect_pc, 32'h0);
      step();
      idle();
      csr_addr = 12'h342;
      #1;
      check("stall mcause", csr_rdata, 32'h0);
      csr_addr = 12'h343;
      #1;
      check("stall mtval", csr_rdata, 32'h0008_0100);
      csr_addr = 12'h341;
      #1;
      check("stall mepc", csr_rdata, 32'h0008_0100);

      // A fault during boot goes straight to halt and stays there.
      do_reset();
      code_e = 4'd4; pc_e = 32'h0008_0200; alu_e = 32'h0000_0003;
      #1;
      check("boot fault redirect", {31'h0, redirect}, 32'h1);
      check("boot fault pc", redirect_pc, 32'h0008_0200);
      step();
      idle();
      pc_e = 32'h0008_0204;
      #1;
      check("boot fault halt", {31'h0, halt}, 32'h1);
      check("boot fault reset_perm", {31'h0, reset_perm}, 32'h0);
      check("boot fault freeze pc", redirect_pc, 32'h0008_0204);
      csr_addr = 12'h342;
      #1;
      check("boot fault mcause", csr_rdata, 32'h0);
      for (int k = 0; k < 3; k++) step();
      #1;
      check("halt sticky", {31'h0, halt}, 32'h1);
      check("halt redirect", {31'h0, redirect}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
